fetch_unit: RTL and testbench

- RV32I instruction fetch stage. It owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- It presents the fetched instruction and its PC to the downstream IF/ID pipeline register over a valid/ready handshake.
- It accepts redirects (branch/jump/trap target) from execute.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, reads instruction memory over req/ack and hands words downstream over valid/ready.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] ResetPC   = 32'h0000_0000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Redirect,
  input  logic [DataWidth-1:0] RedirectPC,
  output logic                 IMemReq,
  output logic [DataWidth-1:0] IMemAddr,
  input  logic                 IMemAck,
  input  logic [DataWidth-1:0] IMemRdata,
  output logic                 InstrValid,
  input  logic                 InstrReady,
  output logic [DataWidth-1:0] Instr,
  output logic [DataWidth-1:0] InstrPC,
  output logic                 MisalignFault
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] HOLD    = 3'd2;
  localparam logic [2:0] DISCARD = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;

  localparam logic [DataWidth-1:0] PcStep = DataWidth'(3'd4);

  logic [2:0]           state_q, state_d;
  logic [DataWidth-1:0] pc_q, pc_d;
  logic                 req_q, req_d;
  logic [DataWidth-1:0] addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic [DataWidth-1:0] ipc_q, ipc_d;
  logic                 fault_q, fault_d;
  logic                 misalign_s;
  logic [DataWidth-1:0] redirect_pc_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_s    = Redirect && (RedirectPC[1:0] != 2'b00);
  assign redirect_pc_s = RedirectPC;
`else
  // Low address bits are forced to zero so every redirect target is word aligned.
  assign misalign_s    = 1'b0;
  assign redirect_pc_s = RedirectPC & {{(DataWidth-2){1'b1}}, 2'b00};
`endif

  // Next-state logic for the fetch FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (misalign_s) begin
      fault_d = 1'b1;
      valid_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end

    case (state_q)
      IDLE: begin
        if (Redirect) begin
          pc_d    = redirect_pc_s;
          state_d = fault_d ? FAULT : IDLE;
        end else begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (Redirect) begin
          pc_d = redirect_pc_s;
          if (IMemAck) begin
            req_d   = 1'b0;
            state_d = fault_d ? FAULT : IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else if (IMemAck) begin
          instr_d = IMemRdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PcStep;
          req_d   = 1'b0;
          state_d = HOLD;
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        // A redirect wins over a handshake on the same edge.
        if (Redirect) begin
          pc_d    = redirect_pc_s;
          valid_d = 1'b0;
          state_d = fault_d ? FAULT : IDLE;
        end else if (InstrReady) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      DISCARD: begin
        if (Redirect) begin
          pc_d = redirect_pc_s;
        end else begin
          pc_d = pc_q;
        end
        if (IMemAck) begin
          req_d   = 1'b0;
          state_d = fault_d ? FAULT : IDLE;
        end else begin
          state_d = DISCARD;
        end
      end
      FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        state_d = FAULT;
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; all updates happen on the falling clock edge.
  always_ff @(negedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= ResetPC;
      req_q   <= 1'b0;
      addr_q  <= ResetPC;
      valid_q <= 1'b0;
      instr_q <= {DataWidth{1'b0}};
      ipc_q   <= {DataWidth{1'b0}};
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

  assign IMemReq       = req_q;
  assign IMemAddr      = addr_q;
  assign InstrValid    = valid_q;
  assign Instr         = instr_q;
  assign InstrPC       = ipc_q;
  assign MisalignFault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue of expected (PC, word) pairs checked by a posedge monitor.
module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRdata;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        MisalignFault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  logic have_exp;
  logic prev_valid;
  int   tests;
  int   fails;
  logic auto_ack;
  int   ack_lat;
  int   wait_cnt;

  fetch_unit #(
    .DataWidth(32),
    .ResetPC  (32'h0000_0100)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemRdata    (IMemRdata),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .MisalignFault(MisalignFault)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hDEAD_0013;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endfunction

  // Step to just after the next falling edge, then run the automatic memory responder.
  task automatic tick();
    @(negedge Clk);
    #1;
    if (auto_ack) begin
      if (IMemReq) begin
        if (wait_cnt >= ack_lat) begin
          IMemAck   = 1'b1;
          IMemRdata = mem_word(IMemAddr);
          wait_cnt  = 0;
        end else begin
          IMemAck  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        IMemAck  = 1'b0;
        wait_cnt = 0;
      end
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!InstrValid && n < budget);
    if (!InstrValid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: timeout after %0d cycles", budget);
    end
  endtask

  task automatic apply_reset();
    Reset    = 1'b0;
    Redirect = 1'b0;
    IMemAck  = 1'b0;
    auto_ack = 1'b0;
    wait_cnt = 0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  // Monitor: every new presentation pops the scoreboard; held outputs are compared every cycle.
  initial begin
    prev_valid = 1'b0;
    have_exp   = 1'b0;
    forever begin
      @(posedge Clk);
      if (InstrValid === 1'b1) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            have_exp = 1'b0;
            $display("FAIL unexpected_instr: got pc %h instr %h expected none", InstrPC, Instr);
          end else begin
            cur_exp  = exp_q.pop_front();
            have_exp = 1'b1;
          end
        end
        if (have_exp) begin
          check("instr", Instr, cur_exp.instr);
          check("instr_pc", InstrPC, cur_exp.pc);
        end
      end
      prev_valid = (InstrValid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests      = 0;
    fails      = 0;
    Reset      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    IMemAck    = 1'b0;
    IMemRdata  = 32'h0;
    InstrReady = 1'b0;
    auto_ack   = 1'b0;
    ack_lat    = 1;
    wait_cnt   = 0;

    // Reset state
    apply_reset();
    check("rst_req", {31'd0, IMemReq}, 32'd0);
    check("rst_addr", IMemAddr, 32'h0000_0100);
    check("rst_valid", {31'd0, InstrValid}, 32'd0);
    check("rst_instr", Instr, 32'h0);
    check("rst_instr_pc", InstrPC, 32'h0);
    check("rst_fault", {31'd0, MisalignFault}, 32'd0);

    // Sequential fetch 0x100, 0x104, 0x108 with a one-cycle memory and a stall on the first word
    auto_ack   = 1'b1;
    ack_lat    = 1;
    InstrReady = 1'b1;
    push_exp(32'h0000_0100);
    push_exp(32'h0000_0104);
    push_exp(32'h0000_0108);
    for (int k = 0; k < 3; k++) begin
      wait_valid(10);
      check("hold_req_low", {31'd0, IMemReq}, 32'd0);
      if (k == 0) begin
        InstrReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick();
          check("stall_valid", {31'd0, InstrValid}, 32'd1);
          check("stall_req", {31'd0, IMemReq}, 32'd0);
          if (i == 1) begin
            IMemAck   = 1'b1;
            IMemRdata = 32'h0BAD_0BAD;
          end
        end
        InstrReady = 1'b1;
        tick();
        check("after_ready_addr", IMemAddr, 32'h0000_0104);
        check("after_ready_req", {31'd0, IMemReq}, 32'd1);
        check("after_ready_valid", {31'd0, InstrValid}, 32'd0);
      end
      if (k == 2) InstrReady = 1'b0;
    end

    // Redirect to 0x200 while a request is outstanding; the late ack is discarded
    apply_reset();
    InstrReady = 1'b1;
    tick();
    check("req_first_addr", IMemAddr, 32'h0000_0100);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0200;
    tick();
    Redirect = 1'b0;
    check("discard_req_held", {31'd0, IMemReq}, 32'd1);
    check("discard_addr_held", IMemAddr, 32'h0000_0100);
    tick();
    tick();
    IMemAck   = 1'b1;
    IMemRdata = 32'hDEAD_BEEF;
    tick();
    IMemAck = 1'b0;
    check("discard_req_drop", {31'd0, IMemReq}, 32'd0);
    check("discard_no_valid", {31'd0, InstrValid}, 32'd0);
    tick();
    check("redir_addr_200", IMemAddr, 32'h0000_0200);
    check("redir_req_200", {31'd0, IMemReq}, 32'd1);
    push_exp(32'h0000_0200);
    IMemAck   = 1'b1;
    IMemRdata = mem_word(32'h0000_0200);
    tick();
    IMemAck = 1'b0;
    check("valid_200", {31'd0, InstrValid}, 32'd1);

    // Redirect to 0x300 on the same edge as a ready handshake
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0300;
    tick();
    Redirect = 1'b0;
    check("ovr_hs_valid", {31'd0, InstrValid}, 32'd0);
    check("ovr_hs_req", {31'd0, IMemReq}, 32'd0);
    tick();
    check("ovr_hs_addr", IMemAddr, 32'h0000_0300);

    // Redirect to 0x300 on the same edge as the ack: data dropped, refetch at 0x300
    IMemAck    = 1'b1;
    IMemRdata  = 32'h1111_1111;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0300;
    tick();
    IMemAck  = 1'b0;
    Redirect = 1'b0;
    check("ack_redir_valid", {31'd0, InstrValid}, 32'd0);
    check("ack_redir_req", {31'd0, IMemReq}, 32'd0);
    tick();
    check("ack_redir_addr", IMemAddr, 32'h0000_0300);
    push_exp(32'h0000_0300);
    IMemAck   = 1'b1;
    IMemRdata = mem_word(32'h0000_0300);
    tick();
    IMemAck = 1'b0;
    check("valid_300", {31'd0, InstrValid}, 32'd1);

    // Wrap-around: 0xFFFF_FFFC then 0x0000_0000
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    tick();
    check("wrap_addr_top", IMemAddr, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC);
    IMemAck   = 1'b1;
    IMemRdata = mem_word(32'hFFFF_FFFC);
    tick();
    IMemAck = 1'b0;
    tick();
    check("wrap_addr_zero", IMemAddr, 32'h0000_0000);
    check("wrap_req", {31'd0, IMemReq}, 32'd1);

    // Reset mid-request, then a late ack that must be ignored
    Reset = 1'b0;
    tick();
    check("midrst_req", {31'd0, IMemReq}, 32'd0);
    check("midrst_addr", IMemAddr, 32'h0000_0100);
    Reset     = 1'b1;
    IMemAck   = 1'b1;
    IMemRdata = 32'h2222_2222;
    tick();
    IMemAck = 1'b0;
    check("late_ack_req", {31'd0, IMemReq}, 32'd1);
    check("late_ack_addr", IMemAddr, 32'h0000_0100);
    check("late_ack_valid", {31'd0, InstrValid}, 32'd0);
    tick();
    check("late_ack_still_req", {31'd0, IMemReq}, 32'd1);
    push_exp(32'h0000_0100);
    InstrReady = 1'b0;
    IMemAck    = 1'b1;
    IMemRdata  = mem_word(32'h0000_0100);
    tick();
    IMemAck = 1'b0;
    check("restart_valid", {31'd0, InstrValid}, 32'd1);

    // Misaligned redirect target 0x202
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0202;
    tick();
    Redirect = 1'b0;
    check("mis_valid", {31'd0, InstrValid}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_fault", {31'd0, MisalignFault}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fault_no_req", {31'd0, IMemReq}, 32'd0);
      check("fault_sticky", {31'd0, MisalignFault}, 32'd1);
    end
`else
    check("mis_fault", {31'd0, MisalignFault}, 32'd0);
    tick();
    check("mis_addr", IMemAddr, 32'h0000_0200);
    check("mis_req", {31'd0, IMemReq}, 32'd1);
    check("mis_fault_after", {31'd0, MisalignFault}, 32'd0);
`endif

    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
